// File: rtl/led_blink_ctrl_pkg.sv
// Shared types for the LED bank controller: op/mode/state codes and the latched header.
package led_blink_ctrl_pkg;

  localparam int NUM_LEDS = 8;

  typedef enum logic [1:0] {
    OP_SET_MODE = 2'b00,
    OP_SET_HALF = 2'b01,
    OP_SYNC     = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [2:0] idx;
  } hdr_t;

  // A zero half-period would never toggle; treat it as the fastest rate instead.
  function automatic logic [7:0] clamp_half(input logic [7:0] a);
    return (a == 8'd0) ? 8'd1 : a;
  endfunction

endpackage

// File: rtl/led_blink_ctrl_channel.sv
// One LED: mode, half-period and blink phase. Commands take priority over the shared tick.
module blink_channel
  import led_blink_ctrl_pkg::*;
#(
  parameter mode_e      DEF_MODE = MODE_OFF,
  parameter logic [7:0] DEF_HALF = 8'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       wr_mode,
  input  mode_e      mode,
  input  logic       wr_half,
  input  logic [7:0] half,
  input  logic       sync,
  output logic       led
);

  mode_e      mode_q, mode_d;
  logic [7:0] half_q, half_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lvl_q, lvl_d;

  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    if (wr_mode) begin
      mode_d = mode;
      cnt_d  = 8'd0;
      lvl_d  = (mode != MODE_OFF);
    end else if (wr_half) begin
      half_d = half;
      cnt_d  = 8'd0;
    end else if (sync && mode_q == MODE_BLINK) begin
      cnt_d = 8'd0;
      lvl_d = 1'b1;
    end else if (mode_q != MODE_BLINK) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      if (cnt_q >= half_q - 8'd1) begin
        cnt_d = 8'd0;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= DEF_MODE;
      half_q <= DEF_HALF;
      cnt_q  <= 8'd0;
      lvl_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  // Level tracks the mode in OFF/ON, so the LED is always the registered level.
  assign led = lvl_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Byte-stream command decoder driving eight blink channels from one shared prescaled tick.
module led_blink_ctrl
  import led_blink_ctrl_pkg::*;
#(
  parameter int         CLK_FREQ      = 25_000_000,
  parameter int         TICK_HZ       = 100,
  parameter logic [7:0] DEF_HALF      = 8'd50,
  parameter int         TIMEOUT_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [7:0]          cmd_data,
  output logic                cmd_ready,
  output logic [NUM_LEDS-1:0] leds,
  output logic                err
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW       = $clog2(TIMEOUT_TICKS + 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  state_e     state_q, state_d;
  hdr_t       hdr_q, hdr_d;
  logic [7:0] arg_q, arg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       xfer, exec, bad_cmd;

  // Header bits [5:3] carry no meaning.
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^cmd_data[5:3];

  assign xfer    = cmd_valid & ready_q;
  assign exec    = (state_q == S_EXEC);
  assign bad_cmd = (hdr_q.op == OP_RSVD) ||
                   (hdr_q.op == OP_SET_MODE && arg_q[1:0] == 2'd3);

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    arg_d   = arg_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          hdr_d   = '{op: op_e'(cmd_data[7:6]), idx: cmd_data[2:0]};
          tmo_d   = '0;
          state_d = S_ARG;
        end
      end
      S_ARG: begin
        if (xfer) begin
          arg_d   = cmd_data;
          state_d = S_EXEC;
        end else if (tick) begin
          if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        err_d   = bad_cmd;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d != S_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      state_q <= S_IDLE;
      hdr_q   <= '{op: OP_SET_MODE, idx: 3'd0};
      arg_q   <= 8'd0;
      tmo_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      hdr_q   <= hdr_d;
      arg_q   <= arg_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign err       = err_q;

  logic [NUM_LEDS-1:0] wr_mode, wr_half;
  logic                sync;
  logic [7:0]          half_arg;
  mode_e               mode_arg;

  assign sync     = exec && hdr_q.op == OP_SYNC;
  assign half_arg = clamp_half(arg_q);
  assign mode_arg = mode_e'(arg_q[1:0]);

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    assign wr_mode[g] = exec && hdr_q.op == OP_SET_MODE && arg_q[1:0] != 2'd3 &&
                        hdr_q.idx == 3'(g);
    assign wr_half[g] = exec && hdr_q.op == OP_SET_HALF && hdr_q.idx == 3'(g);

    blink_channel #(
      .DEF_MODE ((g == 0) ? MODE_BLINK : MODE_OFF),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .wr_mode (wr_mode[g]),
      .mode    (mode_arg),
      .wr_half (wr_half[g]),
      .half    (half_arg),
      .sync    (sync),
      .led     (leds[g])
    );
  end

endmodule
